vga_frame_scheduler: RTL and testbench

Frame-level sequencer for the BMP-to-VGA path. It generates the horizontal and vertical timing (back porch, active image, front porch, sync), fetches one 8-bit pixel per active clock from the frame-buffer read port, and drives a pixel stream with matching HS/VS. It sits between the BMP frame memory and the VGA pixel consumer, and supports single-frame and continuous modes under a start/done handshake.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_counter.sv | 69 ++++++
 rtl/vga_frame_scheduler.sv | 128 ++++++++++++
 tb/tb_vga_frame_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default timing for the BMP-to-VGA frame scheduler.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BACKPORCH,
    ACTIVE,
    FRONTPORCH,
    SYNC
  } line_state_e;

  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_H_ACTIVE = 512;
  localparam int unsigned DEF_H_FP     = 328;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_V_BP     = 23;
  localparam int unsigned DEF_V_ACTIVE = 512;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;

  localparam int unsigned H_TOT = DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC;
  localparam int unsigned V_TOT = DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with region flags for one frame.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned HW       = cnt_width(H_BP + H_ACTIVE + H_FP + H_SYNC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [HW-1:0] h_cnt,
  output logic          h_active,
  output logic          v_active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          end_of_line,
  output logic          end_of_frame
);

  localparam int unsigned LINE_TOT  = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned FRAME_TOT = V_BP + V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned VW        = cnt_width(FRAME_TOT);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clr) begin
      h_d = '0;
      v_d = '0;
    end else if (en) begin
      if (end_of_line) begin
        h_d = '0;
        v_d = end_of_frame ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt        = h_q;
  assign h_active     = (32'(h_q) >= H_BP) && (32'(h_q) < H_BP + H_ACTIVE);
  assign v_active     = (32'(v_q) >= V_BP) && (32'(v_q) < V_BP + V_ACTIVE);
  assign h_sync       = (32'(h_q) >= H_BP + H_ACTIVE + H_FP);
  assign v_sync       = (32'(v_q) >= V_BP + V_ACTIVE + V_FP);
  assign end_of_line  = (32'(h_q) == LINE_TOT - 1);
  assign end_of_frame = end_of_line && (32'(v_q) == FRAME_TOT - 1);

endmodule

// File: rtl/vga_frame_scheduler.sv
// Frame sequencer: line FSM, frame-buffer address generation, 2-stage pixel pipe, aligned HS/VS.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned AW       = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  output logic          busy,
  output logic          frame_done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic [7:0]    out_pixel,
  output logic          out_pixel_valid,
  output logic          HS,
  output logic          VS
);

  localparam int unsigned LINE_TOT = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned HW       = cnt_width(LINE_TOT);

  line_state_e   state_q, state_d;
  logic [HW-1:0] h_cnt;
  logic          h_active, v_active, h_sync, v_sync, end_of_line, end_of_frame;
  logic          running, cnt_clr;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    hs_q, hs_d;
  logic [1:0]    vs_q, vs_d;
  logic [7:0]    pix_q, pix_d;
  logic          done_q, done_d;

  assign running = (state_q != IDLE);
  assign cnt_clr = running && end_of_frame && !continuous;

  vga_sync_counter #(
    .H_BP    (H_BP),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .V_BP    (V_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .HW      (HW)
  ) u_sync_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (running),
    .clr         (cnt_clr),
    .h_cnt       (h_cnt),
    .h_active    (h_active),
    .v_active    (v_active),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .end_of_line (end_of_line),
    .end_of_frame(end_of_frame)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = BACKPORCH;
      BACKPORCH:  if (32'(h_cnt) == H_BP - 1) state_d = ACTIVE;
      ACTIVE:     if (32'(h_cnt) == H_BP + H_ACTIVE - 1) state_d = FRONTPORCH;
      FRONTPORCH: if (32'(h_cnt) == H_BP + H_ACTIVE + H_FP - 1) state_d = SYNC;
      SYNC: begin
        if (end_of_line) state_d = (end_of_frame && !continuous) ? IDLE : BACKPORCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  assign mem_rd = (state_q == ACTIVE) && h_active && v_active;

  // Stage 1 of the pipe is the memory itself; stage 2 captures its data.
  // HS/VS share the same 2-deep delay and drain naturally after the frame ends.
  always_comb begin
    addr_d = addr_q;
    if (!running || end_of_frame) addr_d = '0;
    else if (mem_rd)              addr_d = addr_q + AW'(1);
    vld_d  = {vld_q[0], mem_rd};
    pix_d  = vld_q[0] ? mem_data : '0;
    hs_d   = {hs_q[0], running && h_sync};
    vs_d   = {vs_q[0], running && v_sync};
    done_d = running && end_of_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      vld_q   <= '0;
      pix_q   <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      done_q  <= done_d;
    end
  end

  assign busy            = running;
  assign frame_done      = done_q;
  assign mem_addr        = addr_q;
  assign out_pixel       = pix_q;
  assign out_pixel_valid = vld_q[1];
  assign HS              = hs_q[1];
  assign VS              = vs_q[1];

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized bench for vga_frame_scheduler against a frame-position reference model.
module tb_vga_frame_scheduler;

  localparam int unsigned HBP = 2, HA = 4, HF = 2, HSY = 2;
  localparam int unsigned VBP = 1, VA = 3, VF = 1, VSY = 1;
  localparam int unsigned AW  = 8;
  localparam int unsigned HT  = HBP + HA + HF + HSY;
  localparam int unsigned VT  = VBP + VA + VF + VSY;
  localparam int unsigned FT  = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          busy, frame_done, mem_rd, out_pixel_valid, HS, VS;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'hFF;
  logic [7:0]    out_pixel;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY),
    .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY),
    .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_pixel(out_pixel), .out_pixel_valid(out_pixel_valid),
    .HS(HS), .VS(VS)
  );

  // Frame memory: data for a read appears one cycle later; idle bus reads as 0xFF.
  logic [7:0] lut [256];
  always @(posedge clk) begin : mem_model
    logic          r;
    logic [AW-1:0] a;
    r = mem_rd;
    a = mem_addr;
    #1 mem_data = r ? lut[a] : 8'hFF;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: running flag plus linear position inside the frame.
  bit m_run = 1'b0;
  int m_pos = 0;
  bit m_fd  = 1'b0;
  bit h_rd [2];
  int h_ad [2];
  bit h_hs [2];
  bit h_vs [2];
  int cyc = 0;

  function automatic void raw(input bit run, input int pos,
                              output bit rd, output int ad, output bit hs, output bit vs);
    int h = pos % HT;
    int v = pos / HT;
    rd = run && h >= HBP && h < HBP + HA && v >= VBP && v < VBP + VA;
    ad = rd ? (v - VBP) * HA + (h - HBP) : 0;
    hs = run && h >= HBP + HA + HF;
    vs = run && v >= VBP + VA + VF;
  endfunction

  task automatic compare_all();
    bit rd, hs, vs;
    int ad;
    raw(m_run, m_pos, rd, ad, hs, vs);
    check("busy", busy, m_run);
    check("frame_done", frame_done, m_fd);
    check("mem_rd", mem_rd, rd);
    if (rd || !m_run) check("mem_addr", mem_addr, ad);
    check("out_valid", out_pixel_valid, h_rd[1]);
    check("out_pixel", out_pixel, h_rd[1] ? lut[h_ad[1]] : 8'h00);
    check("HS", HS, h_hs[1]);
    check("VS", VS, h_vs[1]);
  endtask

  task automatic step();
    bit rd, hs, vs;
    int ad;
    @(posedge clk);
    raw(m_run, m_pos, rd, ad, hs, vs);
    h_rd[1] = h_rd[0]; h_ad[1] = h_ad[0]; h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0];
    h_rd[0] = rd;      h_ad[0] = ad;      h_hs[0] = hs;      h_vs[0] = vs;
    m_fd = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_pos = 0;
      for (int i = 0; i < 2; i++) begin
        h_rd[i] = 1'b0; h_ad[i] = 0; h_hs[i] = 1'b0; h_vs[i] = 1'b0;
      end
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == FT - 1) begin
      m_fd  = 1'b1;
      m_pos = 0;
      m_run = continuous;
    end else begin
      m_pos++;
    end
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  // Single frame with stray start pulses mid-frame; checks the headline timing points.
  task automatic run_single(input string tag);
    int c0, f_rd, f_vld, f_done, f_idle;
    f_rd = -1; f_vld = -1; f_done = -1; f_idle = -1;
    c0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < int'(FT) + 8; i++) begin
      if (mem_rd && f_rd < 0)           f_rd   = cyc - c0;
      if (out_pixel_valid && f_vld < 0) f_vld  = cyc - c0;
      if (frame_done && f_done < 0)     f_done = cyc - c0;
      if (!busy && f_idle < 0)          f_idle = cyc - c0;
      start = (i == 20 || i == 35);
      step();
    end
    start = 1'b0;
    check({tag, "_first_rd"},   f_rd,   1 + VBP * HT + HBP);
    check({tag, "_first_vld"},  f_vld,  3 + VBP * HT + HBP);
    check({tag, "_frame_done"}, f_done, FT + 1);
    check({tag, "_busy_low"},   f_idle, FT + 1);
  endtask

  initial begin
    int c0, n_done, last, gap;
    foreach (lut[i]) lut[i] = 8'($urandom);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    run_single("single");

    // Continuous: two back-to-back frames, continuous dropped mid second frame.
    n_done = 0; last = -1; gap = -1;
    c0 = cyc;
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2 * int'(FT) + 10; i++) begin
      if (frame_done) begin
        if (n_done == 1) gap = cyc - last;
        last = cyc;
        n_done++;
      end
      if (cyc - c0 == int'(FT + FT / 2)) continuous = 1'b0;
      step();
    end
    check("cont_done_count", n_done, 2);
    check("cont_done_gap", gap, FT);
    check("cont_idle", busy, 1'b0);

    // Reset in the middle of an active line, then the same frame timing again.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < int'(FT) && !(mem_rd && out_pixel_valid); i++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", out_pixel_valid, 1'b0);
    check("rst_pixel", out_pixel, 0);
    check("rst_hs_vs", {HS, VS}, 0);
    step();
    run_single("after_rst");

    // Random start/continuous/reset traffic against the model.
    for (int i = 0; i < 700; i++) begin
      start = ($urandom_range(5) == 0);
      if ($urandom_range(39) == 0) continuous = ~continuous;
      rst = ($urandom_range(249) == 0);
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    for (int i = 0; i < int'(FT) + 8; i++) step();
    check("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
